// File: rtl/object_store_pkg.sv
// Shared types and helpers for the game-object store: direction codes,
// step-engine states and position field accessors.
package object_store_pkg;

   localparam int unsigned DIR_W       = 2;
   localparam int unsigned MAX_COORD_W = 16;

   localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b10;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   // x lives in the upper half of a packed position, y in the lower half
   function automatic logic [MAX_COORD_W-1:0] pos_x(input logic [2*MAX_COORD_W-1:0] pos,
                                                    input int unsigned cw);
      logic [2*MAX_COORD_W-1:0] mask;
      mask = ~({(2*MAX_COORD_W){1'b1}} << cw);
      return MAX_COORD_W'((pos >> cw) & mask);
   endfunction

   function automatic logic [MAX_COORD_W-1:0] pos_y(input logic [2*MAX_COORD_W-1:0] pos,
                                                    input int unsigned cw);
      logic [2*MAX_COORD_W-1:0] mask;
      mask = ~({(2*MAX_COORD_W){1'b1}} << cw);
      return MAX_COORD_W'(pos & mask);
   endfunction

endpackage

// File: rtl/obj_mover.sv
// Combinational one-cell move of a packed position in a given direction,
// with either wrap-around or kill-at-edge behaviour.
module obj_mover
   import object_store_pkg::*;
#(
   parameter int unsigned COORD_W = 4,
   parameter bit          WRAP    = 1'b1
) (
   input  logic [2*COORD_W-1:0] i_pos,
   input  logic [DIR_W-1:0]     i_dir,
   output logic [2*COORD_W-1:0] o_next_pos_c,
   output logic                 o_kill_c
);

   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
   localparam logic [COORD_W-1:0] MAX = {COORD_W{1'b1}};

   logic [COORD_W-1:0] w_x;
   logic [COORD_W-1:0] w_y;
   logic [COORD_W-1:0] w_nx;
   logic [COORD_W-1:0] w_ny;
   logic               w_edge;

   assign w_x = COORD_W'(pos_x((2*MAX_COORD_W)'(i_pos), COORD_W));
   assign w_y = COORD_W'(pos_y((2*MAX_COORD_W)'(i_pos), COORD_W));

   // Modulo arithmetic by width; w_edge flags a move that would leave the grid
   always_comb begin
      w_nx   = w_x;
      w_ny   = w_y;
      w_edge = 1'b0;
      case (i_dir)
         DIR_UP: begin
            w_ny   = w_y - ONE;
            w_edge = (w_y == '0);
         end
         DIR_RIGHT: begin
            w_nx   = w_x + ONE;
            w_edge = (w_x == MAX);
         end
         DIR_DOWN: begin
            w_ny   = w_y + ONE;
            w_edge = (w_y == MAX);
         end
         default: begin
            w_nx   = w_x - ONE;
            w_edge = (w_x == '0);
         end
      endcase
   end

   assign o_kill_c     = (WRAP == 1'b0) && w_edge;
   assign o_next_pos_c = o_kill_c ? i_pos : {w_nx, w_ny};

endmodule

// File: rtl/object_store.sv
// Game-object slot store: tanks in the low slots, projectiles above them.
// Host write/read ports plus a step engine that advances live projectiles.
module object_store
   import object_store_pkg::*;
#(
   parameter int unsigned  NUM_OBJ   = 8,
   parameter int unsigned  NUM_TANKS = 2,
   parameter int unsigned  COORD_W   = 4,
   parameter bit           WRAP      = 1'b1,
   localparam int unsigned ADDR_W    = $clog2(NUM_OBJ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [2*COORD_W-1:0] wr_pos,
   input  logic [DIR_W-1:0]     wr_dir,
   input  logic                 wr_alive,
   output logic                 wr_err,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [2*COORD_W-1:0] rd_pos,
   output logic [DIR_W-1:0]     rd_dir,
   output logic                 rd_alive,
   output logic                 rd_valid,
   input  logic                 step,
   output logic                 busy,
   output logic                 step_done
);

   localparam int unsigned       POS_W      = 2 * COORD_W;
   localparam logic [ADDR_W-1:0] FIRST_PROJ = ADDR_W'(NUM_TANKS);
   localparam logic [ADDR_W-1:0] LAST_SLOT  = ADDR_W'(NUM_OBJ - 1);

   logic [POS_W-1:0]  r_pos   [NUM_OBJ];
   logic [DIR_W-1:0]  r_dir   [NUM_OBJ];
   logic              r_alive [NUM_OBJ];

   state_e            r_state;
   state_e            w_next_state;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] w_idx_next;
   logic              r_busy;
   logic              r_step_done;
   logic              w_busy_next;
   logic              w_done_next;

   logic              r_wr_err;
   logic [POS_W-1:0]  r_rd_pos;
   logic [DIR_W-1:0]  r_rd_dir;
   logic              r_rd_alive;
   logic              r_rd_valid;

   logic              w_wr_ok;
   logic              w_rd_in_range;
   logic [POS_W-1:0]  w_next_pos;
   logic              w_kill;

   assign w_wr_ok       = wr_en && !r_busy && (32'(wr_addr) < NUM_OBJ);
   assign w_rd_in_range = (32'(rd_addr) < NUM_OBJ);

   obj_mover #(
      .COORD_W (COORD_W),
      .WRAP    (WRAP)
   ) u_mover (
      .i_pos        (r_pos[r_idx]),
      .i_dir        (r_dir[r_idx]),
      .o_next_pos_c (w_next_pos),
      .o_kill_c     (w_kill)
   );

   // Step engine next state; busy/step_done are registered from the next state
   always_comb begin
      w_next_state = r_state;
      w_idx_next   = r_idx;
      w_busy_next  = 1'b0;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (step) begin
               w_next_state = SCAN;
               w_idx_next   = FIRST_PROJ;
            end
         end
         SCAN: begin
            if (r_idx == LAST_SLOT) w_next_state = DONE;
            else                    w_idx_next   = r_idx + ADDR_W'(1);
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
      w_busy_next = (w_next_state == SCAN);
      w_done_next = (w_next_state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_step_done <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_idx       <= w_idx_next;
         r_busy      <= w_busy_next;
         r_step_done <= w_done_next;
      end
   end

   // Host writes and SCAN updates never coincide: writes need busy low
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_OBJ); i++) begin
            r_pos[i]   <= '0;
            r_dir[i]   <= '0;
            r_alive[i] <= 1'b0;
         end
      end else if (w_wr_ok) begin
         r_pos[wr_addr]   <= wr_pos;
         r_dir[wr_addr]   <= wr_dir;
         r_alive[wr_addr] <= wr_alive;
      end else if ((r_state == SCAN) && r_alive[r_idx]) begin
         r_pos[r_idx]   <= w_next_pos;
         r_alive[r_idx] <= !w_kill;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_err   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_pos   <= '0;
         r_rd_dir   <= '0;
         r_rd_alive <= 1'b0;
      end else begin
         r_wr_err   <= wr_en && !w_wr_ok;
         r_rd_valid <= rd_en;
         if (rd_en) begin
            if (w_rd_in_range) begin
               r_rd_pos   <= r_pos[rd_addr];
               r_rd_dir   <= r_dir[rd_addr];
               r_rd_alive <= r_alive[rd_addr];
            end else begin
               r_rd_pos   <= '0;
               r_rd_dir   <= '0;
               r_rd_alive <= 1'b0;
            end
         end
      end
   end

   assign wr_err    = r_wr_err;
   assign rd_pos    = r_rd_pos;
   assign rd_dir    = r_rd_dir;
   assign rd_alive  = r_rd_alive;
   assign rd_valid  = r_rd_valid;
   assign busy      = r_busy;
   assign step_done = r_step_done;

endmodule

// File: tb/tb_object_store.sv
// Directed bench for object_store: a wrapping instance and a kill-at-edge
// instance share all stimulus.
module tb_object_store;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [7:0] wr_pos = '0;
   logic [1:0] wr_dir = '0;
   logic       wr_alive = 1'b0;
   logic       rd_en = 1'b0;
   logic [2:0] rd_addr = '0;
   logic       step = 1'b0;

   logic       wr_err_w, rd_alive_w, rd_valid_w, busy_w, done_w;
   logic [7:0] rd_pos_w;
   logic [1:0] rd_dir_w;
   logic       wr_err_k, rd_alive_k, rd_valid_k, busy_k, done_k;
   logic [7:0] rd_pos_k;
   logic [1:0] rd_dir_k;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   object_store #(.NUM_OBJ(8), .NUM_TANKS(2), .COORD_W(4), .WRAP(1'b1)) dut_w (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_pos(wr_pos), .wr_dir(wr_dir),
      .wr_alive(wr_alive), .wr_err(wr_err_w),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_pos(rd_pos_w), .rd_dir(rd_dir_w),
      .rd_alive(rd_alive_w), .rd_valid(rd_valid_w),
      .step(step), .busy(busy_w), .step_done(done_w)
   );

   object_store #(.NUM_OBJ(8), .NUM_TANKS(2), .COORD_W(4), .WRAP(1'b0)) dut_k (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_pos(wr_pos), .wr_dir(wr_dir),
      .wr_alive(wr_alive), .wr_err(wr_err_k),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_pos(rd_pos_k), .rd_dir(rd_dir_k),
      .rd_alive(rd_alive_k), .rd_valid(rd_valid_k),
      .step(step), .busy(busy_k), .step_done(done_k)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] p, input logic [1:0] d,
                     input logic al);
      wr_en = 1'b1; wr_addr = a; wr_pos = p; wr_dir = d; wr_alive = al;
      tick;
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a);
      rd_en = 1'b1; rd_addr = a;
      tick;
      rd_en = 1'b0;
   endtask

   task automatic run_step(output int busy_n, output int done_at, output int done_n,
                           output logic busy_at_done);
      step = 1'b1;
      tick;
      step = 1'b0;
      busy_n = 0; done_at = 0; done_n = 0; busy_at_done = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         if (busy_w) busy_n++;
         if (done_w) begin
            done_n++;
            if (done_at == 0) done_at = c;
            busy_at_done = busy_w;
         end
         tick;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      n_total++;
      if ({busy_w, done_w, wr_err_w, rd_valid_w, busy_k, done_k} !== 6'b0)
         $display("FAIL reset_outputs: got %b expected 000000",
                  {busy_w, done_w, wr_err_w, rd_valid_w, busy_k, done_k});
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         rd(3'(i));
         n_total++;
         if ({rd_valid_w, rd_pos_w, rd_dir_w, rd_alive_w} !== {1'b1, 8'h00, 2'b00, 1'b0})
            $display("FAIL reset_slot%0d: got %h expected %h", i,
                     {rd_valid_w, rd_pos_w, rd_dir_w, rd_alive_w},
                     {1'b1, 8'h00, 2'b00, 1'b0});
         else n_pass++;
      end
      tick;
      n_total++;
      if (rd_valid_w !== 1'b0)
         $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid_w);
      else n_pass++;
   endtask

   task automatic test_basic_step;
      int   bn, da, dn;
      logic bad;
      wr(3'd3, 8'h55, 2'b01, 1'b1);
      run_step(bn, da, dn, bad);
      n_total++;
      if (bn !== 6) $display("FAIL busy_cycles: got %0d expected 6", bn);
      else n_pass++;
      n_total++;
      if (da !== 7) $display("FAIL done_cycle: got %0d expected 7", da);
      else n_pass++;
      n_total++;
      if (dn !== 1 || bad !== 1'b0)
         $display("FAIL done_pulse: got count %0d busy %b expected count 1 busy 0", dn, bad);
      else n_pass++;
      rd(3'd3);
      n_total++;
      if ({rd_pos_w, rd_dir_w, rd_alive_w} !== {8'h65, 2'b01, 1'b1})
         $display("FAIL move_right: got %h expected %h",
                  {rd_pos_w, rd_dir_w, rd_alive_w}, {8'h65, 2'b01, 1'b1});
      else n_pass++;
   endtask

   task automatic test_wrap_edges;
      int   bn, da, dn;
      logic bad;
      wr(3'd4, 8'hF2, 2'b01, 1'b1);
      wr(3'd6, 8'h30, 2'b00, 1'b1);
      wr(3'd7, 8'h08, 2'b11, 1'b1);
      run_step(bn, da, dn, bad);
      rd(3'd4);
      n_total++;
      if ({rd_pos_w, rd_dir_w, rd_alive_w, rd_pos_k, rd_dir_k, rd_alive_k} !==
          {8'h02, 2'b01, 1'b1, 8'hF2, 2'b01, 1'b0})
         $display("FAIL edge_right: got %h expected %h",
                  {rd_pos_w, rd_dir_w, rd_alive_w, rd_pos_k, rd_dir_k, rd_alive_k},
                  {8'h02, 2'b01, 1'b1, 8'hF2, 2'b01, 1'b0});
      else n_pass++;
      rd(3'd6);
      n_total++;
      if ({rd_pos_w, rd_alive_w, rd_pos_k, rd_alive_k} !== {8'h3F, 1'b1, 8'h30, 1'b0})
         $display("FAIL edge_up: got %h expected %h",
                  {rd_pos_w, rd_alive_w, rd_pos_k, rd_alive_k}, {8'h3F, 1'b1, 8'h30, 1'b0});
      else n_pass++;
      rd(3'd7);
      n_total++;
      if ({rd_pos_w, rd_alive_w, rd_pos_k, rd_alive_k} !== {8'hF8, 1'b1, 8'h08, 1'b0})
         $display("FAIL edge_left: got %h expected %h",
                  {rd_pos_w, rd_alive_w, rd_pos_k, rd_alive_k}, {8'hF8, 1'b1, 8'h08, 1'b0});
      else n_pass++;
      rd(3'd3);
      n_total++;
      if ({rd_pos_k, rd_alive_k} !== {8'h75, 1'b1})
         $display("FAIL nowrap_interior: got %h expected %h",
                  {rd_pos_k, rd_alive_k}, {8'h75, 1'b1});
      else n_pass++;
   endtask

   task automatic test_tank_and_dead;
      int   bn, da, dn;
      logic bad;
      wr(3'd0, 8'h11, 2'b10, 1'b1);
      wr(3'd5, 8'h33, 2'b00, 1'b0);
      run_step(bn, da, dn, bad);
      rd(3'd0);
      n_total++;
      if ({rd_pos_w, rd_dir_w, rd_alive_w} !== {8'h11, 2'b10, 1'b1})
         $display("FAIL tank_untouched: got %h expected %h",
                  {rd_pos_w, rd_dir_w, rd_alive_w}, {8'h11, 2'b10, 1'b1});
      else n_pass++;
      rd(3'd5);
      n_total++;
      if ({rd_pos_w, rd_dir_w, rd_alive_w} !== {8'h33, 2'b00, 1'b0})
         $display("FAIL dead_untouched: got %h expected %h",
                  {rd_pos_w, rd_dir_w, rd_alive_w}, {8'h33, 2'b00, 1'b0});
      else n_pass++;
   endtask

   task automatic test_busy_guard;
      int dn;
      step = 1'b1;
      tick;
      n_total++;
      if (busy_w !== 1'b1) $display("FAIL busy_rise: got %b expected 1", busy_w);
      else n_pass++;
      wr_en = 1'b1; wr_addr = 3'd2; wr_pos = 8'hAA; wr_dir = 2'b11; wr_alive = 1'b1;
      tick;
      wr_en = 1'b0;
      step = 1'b0;
      n_total++;
      if (wr_err_w !== 1'b1) $display("FAIL wr_err_busy: got %b expected 1", wr_err_w);
      else n_pass++;
      dn = 0;
      for (int c = 0; c < 14; c++) begin
         if (done_w) dn++;
         tick;
      end
      n_total++;
      if (dn !== 1) $display("FAIL single_done: got %0d expected 1", dn);
      else n_pass++;
      rd(3'd2);
      n_total++;
      if ({rd_pos_w, rd_dir_w, rd_alive_w} !== {8'h00, 2'b00, 1'b0})
         $display("FAIL busy_write_dropped: got %h expected %h",
                  {rd_pos_w, rd_dir_w, rd_alive_w}, {8'h00, 2'b00, 1'b0});
      else n_pass++;
   endtask

   task automatic test_read_during_write;
      wr_en = 1'b1; wr_addr = 3'd1; wr_pos = 8'h77; wr_dir = 2'b01; wr_alive = 1'b1;
      rd_en = 1'b1; rd_addr = 3'd1;
      tick;
      wr_en = 1'b0; rd_en = 1'b0;
      n_total++;
      if ({rd_valid_w, rd_pos_w, rd_alive_w, wr_err_w} !== {1'b1, 8'h00, 1'b0, 1'b0})
         $display("FAIL rw_same_old: got %h expected %h",
                  {rd_valid_w, rd_pos_w, rd_alive_w, wr_err_w}, {1'b1, 8'h00, 1'b0, 1'b0});
      else n_pass++;
      rd(3'd1);
      tick;
      n_total++;
      if ({rd_valid_w, rd_pos_w, rd_dir_w, rd_alive_w} !== {1'b0, 8'h77, 2'b01, 1'b1})
         $display("FAIL rd_hold: got %h expected %h",
                  {rd_valid_w, rd_pos_w, rd_dir_w, rd_alive_w}, {1'b0, 8'h77, 2'b01, 1'b1});
      else n_pass++;
   endtask

   task automatic test_reset_mid_scan;
      int dn;
      step = 1'b1;
      tick;
      step = 1'b0;
      tick;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      n_total++;
      if ({busy_w, done_w} !== 2'b00)
         $display("FAIL abort_outputs: got %b expected 00", {busy_w, done_w});
      else n_pass++;
      dn = 0;
      for (int c = 0; c < 10; c++) begin
         if (done_w) dn++;
         tick;
      end
      n_total++;
      if (dn !== 0) $display("FAIL abort_no_done: got %0d expected 0", dn);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         rd(3'(i));
         n_total++;
         if ({rd_valid_w, rd_pos_w, rd_dir_w, rd_alive_w} !== {1'b1, 8'h00, 2'b00, 1'b0})
            $display("FAIL abort_slot%0d: got %h expected %h", i,
                     {rd_valid_w, rd_pos_w, rd_dir_w, rd_alive_w},
                     {1'b1, 8'h00, 2'b00, 1'b0});
         else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_basic_step;
      test_wrap_edges;
      test_tank_and_dead;
      test_busy_guard;
      test_read_during_write;
      test_reset_mid_scan;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/object_store.md
Name: object_store

Overview:
- Parametrised successor to the tank/projectile storage block.
- Holds NUM_OBJ game-object slots, each with packed position, direction and alive flag.
- Slots 0..NUM_TANKS-1 are tanks; the remaining slots are projectiles.
- Adds a registered read port, guarded host writes, and a step engine that walks every projectile slot once per step request and advances live projectiles by one cell.

Parameters:
- NUM_OBJ, 8, total slots; must be greater than NUM_TANKS.
- NUM_TANKS, 2, number of tank slots at the low indices.
- COORD_W, 4, bits per coordinate. Position is 2*COORD_W bits: x in the upper half, y in the lower half.
- WRAP, 1, edge policy. 1 = coordinates wrap modulo 2^COORD_W. 0 = a projectile leaving the grid is killed.
- ADDR_W (localparam), $clog2(NUM_OBJ), slot address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe
- wr_addr  in  ADDR_W  slot to write
- wr_pos  in  2*COORD_W  position to store
- wr_dir  in  2  direction to store: 00 up, 01 right, 10 down, 11 left
- wr_alive  in  1  alive flag to store
- wr_err  out  1  one-cycle pulse: write rejected
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  slot to read
- rd_pos  out  2*COORD_W  registered read position
- rd_dir  out  2  registered read direction
- rd_alive  out  1  registered read alive flag
- rd_valid  out  1  one-cycle pulse one cycle after rd_en
- step  in  1  request one movement pass
- busy  out  1  high while the step engine owns the slots
- step_done  out  1  one-cycle pulse at the end of a pass

Behaviour:
Reset
- Every slot is cleared: pos 0, dir 00, alive 0.
- All outputs go to 0 and the FSM goes to IDLE.
- Reset during SCAN aborts the pass with no step_done. Partially updated slots are cleared by the reset.

Writes
- Accepted only when busy=0 and wr_addr < NUM_OBJ. The slot updates at that clock edge.
- wr_en with busy=1 or an out-of-range address is dropped and wr_err pulses on the next cycle.

Reads
- Allowed at any time, including during SCAN; latency is 1 cycle.
- Outputs hold their values until the next rd_en.
- A read and a write to the same slot in the same cycle returns the old contents.
- An out-of-range rd_addr returns all zeros with rd_valid=1.

FSM: IDLE -> SCAN -> DONE -> IDLE.
- IDLE: step=1 loads idx=NUM_TANKS; busy rises on the next cycle. step while busy is ignored.
- SCAN: processes one projectile slot per cycle, idx from NUM_TANKS to NUM_OBJ-1, which takes NUM_OBJ-NUM_TANKS cycles. After the last slot the FSM goes to DONE.
- DONE: step_done=1 for one cycle and busy=0 in that cycle. Next state is IDLE.
- A step_done/step collision cannot occur, since busy is already 0.

Slot update during SCAN
- Dead slots are untouched. Tank slots are never modified by step.
- Moves: up y-1, down y+1, right x+1, left x-1.
- WRAP=1: arithmetic is modulo 2^COORD_W.
- WRAP=0: these edge cases clear alive and leave pos unchanged: y=0 moving up, y=max moving down, x=max moving right, x=0 moving left.
- Direction is never modified by step.

Decomposition:
- Package object_store_pkg holds:
  - direction constants DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT
  - state enum IDLE, SCAN, DONE
  - pos field helper functions for extracting x and y
- Sub-module obj_mover: combinational. Inputs pos, dir, WRAP. Outputs next_pos and kill. Reused later for tank movement.

Test Plan:
1. Reset, then read slots 0..7 -> rd_valid pulses one cycle after each rd_en; all fields read 0.
2. Write slot 3 with pos 8'h55, dir 01, alive 1; issue step -> busy for 6 cycles; step_done on cycle 7 after step; slot 3 reads pos 8'h65.
3. WRAP=1: slot 4 holds pos 8'hF2, dir 01, alive 1; step -> pos 8'h02, alive 1. WRAP=0 with the same setup -> alive 0, pos 8'hF2.
4. Tank slot 0 alive with dir 10, plus dead projectile slot 5 at pos 8'h33; step -> both slots unchanged.
5. wr_en to slot 2 while busy=1 -> wr_err pulses; slot 2 is unchanged after step_done. A second step pulse mid-SCAN -> exactly one step_done.
6. reset asserted on the 3rd SCAN cycle -> no step_done; busy=0 next cycle; every slot reads 0.
